// File: rtl/if_id_pkg.sv
// Shared types and encoding constants for the LEGv8 fetch/decode stage.
package if_id_pkg;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_D_LOAD  = 3'd1,
    CLS_D_STORE = 3'd2,
    CLS_B       = 3'd3,
    CLS_CB_COND = 3'd4,
    CLS_CBZ     = 3'd5,
    CLS_INVALID = 3'd6
  } instr_class_t;

  // Full 11-bit opcodes
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_EOR  = 11'b11001010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  // Short-prefix opcodes: B uses [31:26], CB forms use [31:24]
  localparam logic [5:0] OPC_B     = 6'b000101;
  localparam logic [7:0] OPC_BCOND = 8'b01010100;
  localparam logic [7:0] OPC_CBZ   = 8'b10110100;

  // Field positions within the instruction word
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 21;
  localparam int B_MSB     = 31;
  localparam int B_LSB     = 26;
  localparam int CB_MSB    = 31;
  localparam int CB_LSB    = 24;
  localparam int RM_MSB    = 20;
  localparam int RM_LSB    = 16;
  localparam int RN_MSB    = 9;
  localparam int RN_LSB    = 5;
  localparam int RD_MSB    = 4;
  localparam int RD_LSB    = 0;
  localparam int COND_MSB  = 3;
  localparam int COND_LSB  = 0;
  localparam int IMM26_MSB = 25;
  localparam int IMM26_LSB = 0;
  localparam int IMM19_MSB = 23;
  localparam int IMM19_LSB = 5;
  localparam int IMM9_MSB  = 20;
  localparam int IMM9_LSB  = 12;

  function automatic logic is_r_opcode(input logic [10:0] opc);
    return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_AND) ||
           (opc == OPC_ORR) || (opc == OPC_EOR);
  endfunction

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Decode-register output bundle with valid/ready handshake.
interface fetch_decode_stage_if
  import if_id_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic              OutValid;
  logic              OutReady;
  logic [ADDR_W-1:0] OutPc;
  instr_class_t      OutClass;
  logic [10:0]       OutOpcode;
  logic [4:0]        Rd;
  logic [4:0]        Rn;
  logic [4:0]        Rm;
  logic [3:0]        OutCond;
  logic [ADDR_W-1:0] OutImm;
  logic              OutPredTaken;

  modport master (
    output OutValid, OutPc, OutClass, OutOpcode, Rd, Rn, Rm, OutCond, OutImm, OutPredTaken,
    input  OutReady
  );

  modport slave (
    input  OutValid, OutPc, OutClass, OutOpcode, Rd, Rn, Rm, OutCond, OutImm, OutPredTaken,
    output OutReady
  );
endinterface

// File: rtl/legv8_decoder.sv
// Combinational LEGv8 decoder: class, register fields and sign-extended immediate.
module legv8_decoder
  import if_id_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [31:0]       i_instr,
  output instr_class_t      o_class,
  output logic [10:0]       o_opcode,
  output logic [4:0]        o_rd,
  output logic [4:0]        o_rn,
  output logic [4:0]        o_rm,
  output logic [3:0]        o_cond,
  output logic [ADDR_W-1:0] o_imm
);

  logic signed [27:0] w_b_off;
  logic signed [20:0] w_cb_off;
  logic signed [8:0]  w_d_off;

  assign o_opcode = i_instr[OPC_MSB:OPC_LSB];
  assign o_rd     = i_instr[RD_MSB:RD_LSB];
  assign o_rn     = i_instr[RN_MSB:RN_LSB];
  assign o_rm     = i_instr[RM_MSB:RM_LSB];
  assign o_cond   = i_instr[COND_MSB:COND_LSB];

  // Branch offsets are word counts, so shift before sign-extending to ADDR_W.
  assign w_b_off  = {i_instr[IMM26_MSB:IMM26_LSB], 2'b00};
  assign w_cb_off = {i_instr[IMM19_MSB:IMM19_LSB], 2'b00};
  assign w_d_off  = i_instr[IMM9_MSB:IMM9_LSB];

  // Classify the word; anything unrecognised is still passed on as INVALID.
  always_comb begin
    o_class = CLS_INVALID;
    if (is_r_opcode(o_opcode))                  o_class = CLS_R;
    else if (o_opcode == OPC_LDUR)              o_class = CLS_D_LOAD;
    else if (o_opcode == OPC_STUR)              o_class = CLS_D_STORE;
    else if (i_instr[B_MSB:B_LSB] == OPC_B)     o_class = CLS_B;
    else if (i_instr[CB_MSB:CB_LSB] == OPC_BCOND) o_class = CLS_CB_COND;
    else if (i_instr[CB_MSB:CB_LSB] == OPC_CBZ)   o_class = CLS_CBZ;
  end

  // Select the immediate for the class; R and INVALID carry zero.
  always_comb begin
    o_imm = '0;
    case (o_class)
      CLS_B:                  o_imm = ADDR_W'(w_b_off);
      CLS_CB_COND, CLS_CBZ:   o_imm = ADDR_W'(w_cb_off);
      CLS_D_LOAD, CLS_D_STORE: o_imm = ADDR_W'(w_d_off);
      default:                o_imm = '0;
    endcase
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// LEGv8 fetch + decode stage: owns the PC, drives a synchronous-read
// instruction memory and presents decoded instructions on a valid/ready register.
// Optional feature macro: STATIC_BRANCH_EN (predict unconditional B at fetch).
module fetch_decode_stage
  import if_id_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  output logic [ADDR_W-1:0]    ImemAddr,
  input  logic [31:0]          ImemData,
  input  logic                 Redirect,
  input  logic [ADDR_W-1:0]    RedirectPc,
  fetch_decode_stage_if.master out_if
);

  // Fetch state: r_fpc is the address whose word is on ImemData now.
  logic [ADDR_W-1:0] r_fpc;
  logic              r_fvalid;

  // Decode register
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_pc;
  instr_class_t      r_out_class;
  logic [10:0]       r_out_opcode;
  logic [4:0]        r_rd;
  logic [4:0]        r_rn;
  logic [4:0]        r_rm;
  logic [3:0]        r_cond;
  logic [ADDR_W-1:0] r_imm;

  instr_class_t      w_class;
  logic [10:0]       w_opcode;
  logic [4:0]        w_rd;
  logic [4:0]        w_rn;
  logic [4:0]        w_rm;
  logic [3:0]        w_cond;
  logic [ADDR_W-1:0] w_imm;

  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_advance;
  logic              w_load;
  logic              w_unused_redirect_lsbs;

  legv8_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .i_instr  (ImemData),
    .o_class  (w_class),
    .o_opcode (w_opcode),
    .o_rd     (w_rd),
    .o_rn     (w_rn),
    .o_rm     (w_rm),
    .o_cond   (w_cond),
    .o_imm    (w_imm)
  );

  // Redirect targets are forced word aligned.
  assign w_target  = {RedirectPc[ADDR_W-1:2], 2'b00};
  assign w_unused_redirect_lsbs = ^RedirectPc[1:0];
  assign w_advance = !r_out_valid || out_if.OutReady;

  // Next fetch address: redirect > refetch after reset > advance > stall re-read.
  always_comb begin
    w_fetch_addr = r_fpc;
    w_load       = 1'b0;
    if (Redirect) begin
      w_fetch_addr = w_target;
    end else if (!r_fvalid) begin
      w_fetch_addr = r_fpc;
    end else if (w_advance) begin
      w_load = 1'b1;
`ifdef STATIC_BRANCH_EN
      w_fetch_addr = (w_class == CLS_B) ? (r_fpc + w_imm) : (r_fpc + ADDR_W'(4));
`else
      w_fetch_addr = r_fpc + ADDR_W'(4);
`endif
    end
  end

  assign ImemAddr = w_fetch_addr;

  // Fetch PC tracks whatever address the memory registered this edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_fpc    <= RESET_PC;
      r_fvalid <= 1'b0;
    end else begin
      r_fvalid <= 1'b1;
      if (Redirect || w_load) r_fpc <= w_fetch_addr;
    end
  end

  // Decode register: flush on redirect, load on advance, otherwise hold.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_out_valid  <= 1'b0;
      r_out_pc     <= '0;
      r_out_class  <= CLS_INVALID;
      r_out_opcode <= '0;
      r_rd         <= '0;
      r_rn         <= '0;
      r_rm         <= '0;
      r_cond       <= '0;
      r_imm        <= '0;
    end else if (Redirect) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_pc     <= r_fpc;
      r_out_class  <= w_class;
      r_out_opcode <= w_opcode;
      r_rd         <= w_rd;
      r_rn         <= w_rn;
      r_rm         <= w_rm;
      r_cond       <= w_cond;
      r_imm        <= w_imm;
    end
  end

`ifdef STATIC_BRANCH_EN
  logic r_pred;

  // Mark a B that fetch already followed, so execute does not redirect it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_pred <= 1'b0;
    end else if (!Redirect && w_load) begin
      r_pred <= (w_class == CLS_B);
    end
  end

  assign out_if.OutPredTaken = r_pred;
`else
  assign out_if.OutPredTaken = 1'b0;
`endif

  assign out_if.OutValid  = r_out_valid;
  assign out_if.OutPc     = r_out_pc;
  assign out_if.OutClass  = r_out_class;
  assign out_if.OutOpcode = r_out_opcode;
  assign out_if.Rd        = r_rd;
  assign out_if.Rn        = r_rn;
  assign out_if.Rm        = r_rm;
  assign out_if.OutCond   = r_cond;
  assign out_if.OutImm    = r_imm;

endmodule
